// File: rtl/fp_add_arbiter_if.sv
// Request, adder and response signals around the shared FP add/sub arbiter.
// The slave view belongs to the arbiter, the master view to its surroundings
// (requesters, combinational adder and response consumer).
interface fp_add_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              i_req0_valid;
   logic              o_req0_ready;
   logic [DATA_W-1:0] i_req0_a;
   logic [DATA_W-1:0] i_req0_b;
   logic              i_req0_op;
   logic              i_req1_valid;
   logic              o_req1_ready;
   logic [DATA_W-1:0] i_req1_a;
   logic [DATA_W-1:0] i_req1_b;
   logic              i_req1_op;
   logic [DATA_W-1:0] o_fpu_a;
   logic [DATA_W-1:0] o_fpu_b;
   logic              o_fpu_op;
   logic [DATA_W-1:0] i_fpu_result;
   logic              o_rsp_valid;
   logic              i_rsp_ready;
   logic [DATA_W-1:0] o_rsp_data;
   logic              o_rsp_id;

   modport slave (
      input  i_req0_valid, i_req0_a, i_req0_b, i_req0_op,
             i_req1_valid, i_req1_a, i_req1_b, i_req1_op,
             i_fpu_result, i_rsp_ready,
      output o_req0_ready, o_req1_ready, o_fpu_a, o_fpu_b, o_fpu_op,
             o_rsp_valid, o_rsp_data, o_rsp_id
   );

   modport master (
      output i_req0_valid, i_req0_a, i_req0_b, i_req0_op,
             i_req1_valid, i_req1_a, i_req1_b, i_req1_op,
             i_fpu_result, i_rsp_ready,
      input  o_req0_ready, o_req1_ready, o_fpu_a, o_fpu_b, o_fpu_op,
             o_rsp_valid, o_rsp_data, o_rsp_id
   );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one combinational FP adder between two requesters.
// Operands are registered onto the adder, held for STAGE_CYC cycles
// (multicycle path), then the result is captured and returned with the
// id of the requester that issued it.
module fp_add_arbiter #(
   parameter int DATA_W    = 32,
   parameter int STAGE_CYC = 1    // legal range 1..15
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   fp_add_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Counter is loaded with STAGE_CYC-1 so capture happens on the
   // STAGE_CYC-th edge after the handshake.
   localparam logic [3:0] CNT_INIT = 4'(STAGE_CYC - 1);

   state_t            state_reg, state_next;
   logic              last_grant_reg;
   logic              id_reg;
   logic [3:0]        cnt_reg;
   logic [DATA_W-1:0] fpu_a_reg, fpu_b_reg, rsp_data_reg;
   logic              fpu_op_reg, rsp_valid_reg, rsp_id_reg;

   logic [1:0]        req_valid, req_op, ready_vec;
   logic [DATA_W-1:0] req_a [2];
   logic [DATA_W-1:0] req_b [2];
   logic              grant_id;
   logic              accept;

   assign req_valid = {bus.i_req1_valid, bus.i_req0_valid};
   assign req_op    = {bus.i_req1_op, bus.i_req0_op};
   assign req_a[0]  = bus.i_req0_a;
   assign req_a[1]  = bus.i_req1_a;
   assign req_b[0]  = bus.i_req0_b;
   assign req_b[1]  = bus.i_req1_b;

   // A lone requester wins outright; on a tie the one not granted last wins.
   assign grant_id = (&req_valid) ? ~last_grant_reg : req_valid[1];

   // Ready is only offered in IDLE and only to the granted requester.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ready
         assign ready_vec[gi] = (state_reg == IDLE) && req_valid[gi] &&
                                (grant_id == 1'(gi));
      end
   endgenerate

   assign accept = |ready_vec;

   // Next-state decode.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = CALC;
         CALC:    if (cnt_reg == 4'd0) state_next = RESP;
         RESP:    if (bus.i_rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register; a reset mid-operation simply abandons the transaction.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   // Operand launch, multicycle count and result capture.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_grant_reg <= 1'b1;
         id_reg         <= 1'b0;
         cnt_reg        <= 4'd0;
         fpu_a_reg      <= '0;
         fpu_b_reg      <= '0;
         fpu_op_reg     <= 1'b0;
         rsp_data_reg   <= '0;
         rsp_id_reg     <= 1'b0;
         rsp_valid_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  fpu_a_reg      <= req_a[grant_id];
                  fpu_b_reg      <= req_b[grant_id];
                  fpu_op_reg     <= req_op[grant_id];
                  id_reg         <= grant_id;
                  last_grant_reg <= grant_id;
                  cnt_reg        <= CNT_INIT;
               end
            end
            CALC: begin
               if (cnt_reg != 4'd0) begin
                  cnt_reg <= cnt_reg - 4'd1;
               end else begin
                  rsp_data_reg  <= bus.i_fpu_result;
                  rsp_id_reg    <= id_reg;
                  rsp_valid_reg <= 1'b1;
               end
            end
            RESP: begin
               if (bus.i_rsp_ready) rsp_valid_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_req0_ready = ready_vec[0];
   assign bus.o_req1_ready = ready_vec[1];
   assign bus.o_fpu_a      = fpu_a_reg;
   assign bus.o_fpu_b      = fpu_b_reg;
   assign bus.o_fpu_op     = fpu_op_reg;
   assign bus.o_rsp_valid  = rsp_valid_reg;
   assign bus.o_rsp_data   = rsp_data_reg;
   assign bus.o_rsp_id     = rsp_id_reg;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: one instance with STAGE_CYC=1 (table, backpressure,
// contention, random and reset tests) and one with STAGE_CYC=3 (multicycle).
module tb_fp_add_arbiter;
   localparam int DATA_W = 32;

   logic i_clk = 1'b0;
   logic i_rst_n = 1'b0;
   always #5 i_clk = ~i_clk;

   fp_add_arbiter_if #(.DATA_W(DATA_W)) b1 ();
   fp_add_arbiter_if #(.DATA_W(DATA_W)) b3 ();

   fp_add_arbiter #(.DATA_W(DATA_W), .STAGE_CYC(1)) u_dut1 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b1));
   fp_add_arbiter #(.DATA_W(DATA_W), .STAGE_CYC(3)) u_dut3 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b3));

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- floating point reference (exact for the operand ranges used)
   function automatic real to_real(input logic [31:0] x);
      real m;
      int  e;
      if (x[30:0] == 31'd0) return 0.0;
      m = 1.0 + real'(x[22:0]) / 8388608.0;
      e = int'(x[30:23]) - 127;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return x[31] ? -m : m;
   endfunction

   function automatic logic [31:0] from_real(input real r);
      logic   s;
      int     e;
      real    m;
      longint frac;
      if (r == 0.0) return 32'h0;
      s = (r < 0.0);
      m = s ? -r : r;
      e = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0) begin m = m * 2.0; e--; end
      frac = longint'((m - 1.0) * 8388608.0);
      return {s, 8'(e + 127), 23'(frac)};
   endfunction

   function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic op);
      return from_real(op ? to_real(a) - to_real(b) : to_real(a) + to_real(b));
   endfunction

   // Random normal operand: 12 significant bits, exponent 2^-3..2^3, so sums stay exact.
   function automatic logic [31:0] rand_fp();
      logic [31:0] x;
      x[31]    = 1'($urandom_range(0, 1));
      x[30:23] = 8'($urandom_range(124, 130));
      x[22:12] = 11'($urandom);
      x[11:0]  = 12'd0;
      return x;
   endfunction

   // Combinational adders seen by the two instances.
   assign b1.i_fpu_result = fp_ref(b1.o_fpu_a, b1.o_fpu_b, b1.o_fpu_op);
   assign b3.i_fpu_result = fp_ref(b3.o_fpu_a, b3.o_fpu_b, b3.o_fpu_op);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expd);
      n_checks++;
      if (act !== expd) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, expd, $time);
      end
   endtask

   // ---------------- scoreboard on instance 1 (sampled on the falling edge)
   typedef struct packed {
      logic        id;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   grant_log[$];
   int   grant_cyc[$];
   bit   log_en  = 1'b0;
   logic last_id = 1'b1;
   int   cyc     = 0;

   always @(negedge i_clk) begin
      exp_t e;
      cyc++;
      if (!i_rst_n) begin
         exp_q.delete();
         last_id = 1'b1;
      end else begin
         if (b1.o_req0_ready || b1.o_req1_ready)
            check("ready_excl", 32'(b1.o_req0_ready & b1.o_req1_ready), 32'd0);
         if (b1.i_req0_valid && b1.o_req0_ready) begin
            exp_q.push_back('{id: 1'b0, data: fp_ref(b1.i_req0_a, b1.i_req0_b, b1.i_req0_op)});
            last_id = 1'b0;
            if (log_en) begin grant_log.push_back(0); grant_cyc.push_back(cyc); end
         end
         if (b1.i_req1_valid && b1.o_req1_ready) begin
            exp_q.push_back('{id: 1'b1, data: fp_ref(b1.i_req1_a, b1.i_req1_b, b1.i_req1_op)});
            last_id = 1'b1;
            if (log_en) begin grant_log.push_back(1); grant_cyc.push_back(cyc); end
         end
         if (b1.o_rsp_valid && b1.i_rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("mon_data", b1.o_rsp_data, e.data);
               check("mon_id", 32'(b1.o_rsp_id), 32'(e.id));
               $display("rsp id=%0d data=%h", b1.o_rsp_id, b1.o_rsp_data);
            end
         end
      end
   end

   // ---------------- instance 1 drive helpers
   task automatic drive1(input logic r, input logic [31:0] a, input logic [31:0] b,
                         input logic op);
      if (r) begin
         b1.i_req1_a = a; b1.i_req1_b = b; b1.i_req1_op = op; b1.i_req1_valid = 1'b1;
      end else begin
         b1.i_req0_a = a; b1.i_req0_b = b; b1.i_req0_op = op; b1.i_req0_valid = 1'b1;
      end
   endtask

   task automatic drop1(input logic r);
      if (r) b1.i_req1_valid = 1'b0;
      else   b1.i_req0_valid = 1'b0;
   endtask

   function automatic logic ready_of1(input logic r);
      return r ? b1.o_req1_ready : b1.o_req0_ready;
   endfunction

   // Returns on the falling edge where the requester sees ready (or budget ends).
   task automatic wait_ready1(input logic r, input string tag);
      int n = 0;
      @(negedge i_clk);
      while (!ready_of1(r) && n < 100) begin @(negedge i_clk); n++; end
      check({tag, "_ready"}, 32'(ready_of1(r)), 32'd1);
   endtask

   // Called just after the handshake edge; counts edges until o_rsp_valid.
   task automatic wait_rsp1(output int lat);
      lat = 0;
      @(negedge i_clk);
      while (!b1.o_rsp_valid && lat < 40) begin
         @(posedge i_clk); lat++; @(negedge i_clk);
      end
   endtask

   // One complete operation on instance 1 with an always-ready consumer.
   task automatic do_op1(input logic r, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] expd, input string tag);
      int lat;
      @(posedge i_clk); #1;
      drive1(r, a, b, op);
      wait_ready1(r, tag);
      @(posedge i_clk); #1;
      drop1(r);
      @(negedge i_clk);
      check({tag, "_fpu_a"}, b1.o_fpu_a, a);
      check({tag, "_fpu_b"}, b1.o_fpu_b, b);
      check({tag, "_fpu_op"}, 32'(b1.o_fpu_op), 32'(op));
      check({tag, "_ready_1cyc"}, 32'(b1.o_req0_ready | b1.o_req1_ready), 32'd0);
      lat = 0;
      while (!b1.o_rsp_valid && lat < 40) begin
         @(posedge i_clk); lat++; @(negedge i_clk);
      end
      check({tag, "_lat"}, 32'(lat), 32'd1);
      check({tag, "_data"}, b1.o_rsp_data, expd);
      check({tag, "_id"}, 32'(b1.o_rsp_id), 32'(r));
      @(negedge i_clk);
      check({tag, "_rsp_1cyc"}, 32'(b1.o_rsp_valid), 32'd0);
      $display("op %s req%0d a=%h b=%h op=%0d -> %h", tag, r, a, b, op, expd);
   endtask

   // Stream of n operations from one requester; gaps=0 keeps valid continuous.
   task automatic req_stream(input logic r, input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         int k;
         k = gaps ? int'($urandom_range(0, 4)) : 0;
         if (k > 0) begin
            repeat (k) @(posedge i_clk);
            #1;
         end
         drive1(r, rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
         wait_ready1(r, r ? "rq1" : "rq0");
         @(posedge i_clk); #1;
         drop1(r);
      end
   endtask

   task automatic drain1(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin @(negedge i_clk); n++; end
      check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- directed vectors
   typedef struct {
      logic        id;
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [31:0] expd;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [31:0] held_a, held_b;
      logic        held_op, first;
      bit          rnd_done;

      vecs[0] = '{1'b0, 32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000}; // 1.5+2.25
      vecs[1] = '{1'b1, 32'h40700000, 32'h3FC00000, 1'b1, 32'h40100000}; // 3.75-1.5
      vecs[2] = '{1'b0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000}; // 1+1
      vecs[3] = '{1'b1, 32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000}; // 1-3
      vecs[4] = '{1'b0, 32'h40000000, 32'h40000000, 1'b1, 32'h00000000}; // 2-2
      vecs[5] = '{1'b1, 32'hC0200000, 32'h3F000000, 1'b0, 32'hC0000000}; // -2.5+0.5

      b1.i_req0_valid = 0; b1.i_req0_a = 0; b1.i_req0_b = 0; b1.i_req0_op = 0;
      b1.i_req1_valid = 0; b1.i_req1_a = 0; b1.i_req1_b = 0; b1.i_req1_op = 0;
      b1.i_rsp_ready  = 1;
      b3.i_req0_valid = 0; b3.i_req0_a = 0; b3.i_req0_b = 0; b3.i_req0_op = 0;
      b3.i_req1_valid = 0; b3.i_req1_a = 0; b3.i_req1_b = 0; b3.i_req1_op = 0;
      b3.i_rsp_ready  = 1;

      // Reset state
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_fpu_a", b1.o_fpu_a, 32'd0);
      check("rst_fpu_b", b1.o_fpu_b, 32'd0);
      check("rst_fpu_op", 32'(b1.o_fpu_op), 32'd0);
      check("rst_rsp_valid", 32'(b1.o_rsp_valid), 32'd0);
      check("rst_rsp_data", b1.o_rsp_data, 32'd0);
      check("rst_rsp_id", 32'(b1.o_rsp_id), 32'd0);
      check("rst_ready", 32'({b1.o_req1_ready, b1.o_req0_ready}), 32'd0);
      @(posedge i_clk); #3;
      i_rst_n = 1'b1;

      // Table-driven single operations
      for (int i = 0; i < 6; i++)
         do_op1(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].expd, $sformatf("vec%0d", i));

      // Multicycle path on the STAGE_CYC=3 instance
      @(posedge i_clk); #1;
      b3.i_req0_a = 32'h3F800000; b3.i_req0_b = 32'h3F800000; b3.i_req0_op = 1'b0;
      b3.i_req0_valid = 1'b1;
      lat = 0;
      @(negedge i_clk);
      while (!b3.o_req0_ready && lat < 50) begin @(negedge i_clk); lat++; end
      check("mc_ready", 32'(b3.o_req0_ready), 32'd1);
      @(posedge i_clk); #1;
      b3.i_req0_valid = 1'b0;
      @(negedge i_clk);
      held_a = b3.o_fpu_a; held_b = b3.o_fpu_b; held_op = b3.o_fpu_op;
      check("mc_fpu_a", held_a, 32'h3F800000);
      check("mc_fpu_b", held_b, 32'h3F800000);
      lat = 0;
      while (!b3.o_rsp_valid && lat < 40) begin
         @(posedge i_clk); lat++; @(negedge i_clk);
         check("mc_hold_a", b3.o_fpu_a, held_a);
         check("mc_hold_b", b3.o_fpu_b, held_b);
         check("mc_hold_op", 32'(b3.o_fpu_op), 32'(held_op));
      end
      check("mc_lat", 32'(lat), 32'd3);
      check("mc_data", b3.o_rsp_data, 32'h40000000);
      check("mc_data_ref", b3.o_rsp_data, fp_ref(held_a, held_b, held_op));
      check("mc_id", 32'(b3.o_rsp_id), 32'd0);
      @(negedge i_clk);
      check("mc_rsp_1cyc", 32'(b3.o_rsp_valid), 32'd0);
      $display("op mc req0 a=%h b=%h op=%0d lat=%0d", held_a, held_b, held_op, lat);

      // Response backpressure
      b1.i_rsp_ready = 1'b0;
      @(posedge i_clk); #1;
      drive1(0, 32'h3F800000, 32'h40000000, 1'b0);          // 1+2 = 3
      wait_ready1(0, "bp");
      @(posedge i_clk); #1;
      drop1(0);
      drive1(1, 32'h40400000, 32'h3F800000, 1'b1);          // 3-1 = 2, waits
      wait_rsp1(lat);
      check("bp_lat", 32'(lat), 32'd1);
      check("bp_data0", b1.o_rsp_data, 32'h40400000);
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         check("bp_valid", 32'(b1.o_rsp_valid), 32'd1);
         check("bp_data", b1.o_rsp_data, 32'h40400000);
         check("bp_id", 32'(b1.o_rsp_id), 32'd0);
         check("bp_no_ready", 32'({b1.o_req1_ready, b1.o_req0_ready}), 32'd0);
      end
      b1.i_rsp_ready = 1'b1;
      @(negedge i_clk);
      check("bp_released", 32'(b1.o_rsp_valid), 32'd0);
      check("bp_next_ready", 32'(b1.o_req1_ready), 32'd1);
      @(posedge i_clk); #1;
      drop1(1);
      wait_rsp1(lat);
      check("bp2_data", b1.o_rsp_data, 32'h40000000);
      check("bp2_id", 32'(b1.o_rsp_id), 32'd1);
      @(negedge i_clk);
      $display("op bp done");

      // Contention: both requesters continuously valid
      grant_log.delete(); grant_cyc.delete();
      first = ~last_id;
      log_en = 1'b1;
      @(posedge i_clk); #1;
      fork
         req_stream(0, 4, 1'b0);
         req_stream(1, 4, 1'b0);
      join
      drain1("cont");
      log_en = 1'b0;
      check("cont_count", 32'(grant_log.size()), 32'd8);
      for (int k = 0; k < grant_log.size(); k++) begin
         check($sformatf("cont_order%0d", k), 32'(grant_log[k]), 32'(first ^ k[0]));
         if (k > 0)
            check($sformatf("cont_space%0d", k), 32'(grant_cyc[k] - grant_cyc[k-1]), 32'd3);
      end
      $display("op contention %0d grants", grant_log.size());

      // Random traffic with random response backpressure
      rnd_done = 1'b0;
      @(posedge i_clk); #1;
      fork
         begin
            fork
               req_stream(0, 20, 1'b1);
               req_stream(1, 20, 1'b1);
            join
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge i_clk); #1;
               b1.i_rsp_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      b1.i_rsp_ready = 1'b1;
      drain1("rnd");

      // Reset in the middle of an operation
      @(posedge i_clk); #1;
      drive1(1, 32'h40400000, 32'h40000000, 1'b0);          // 3+2, to be dropped
      wait_ready1(1, "rst_pre");
      @(posedge i_clk); #1;
      drop1(1);
      @(negedge i_clk); #2;
      i_rst_n = 1'b0;
      #1;
      check("mrst_fpu_a", b1.o_fpu_a, 32'd0);
      check("mrst_fpu_b", b1.o_fpu_b, 32'd0);
      check("mrst_fpu_op", 32'(b1.o_fpu_op), 32'd0);
      check("mrst_rsp_valid", 32'(b1.o_rsp_valid), 32'd0);
      check("mrst_rsp_data", b1.o_rsp_data, 32'd0);
      check("mrst_rsp_id", 32'(b1.o_rsp_id), 32'd0);
      check("mrst_ready", 32'({b1.o_req1_ready, b1.o_req0_ready}), 32'd0);
      repeat (2) @(posedge i_clk);
      #3;
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      drive1(0, 32'h3FC00000, 32'h3FC00000, 1'b0);          // 1.5+1.5 = 3
      drive1(1, 32'h3F800000, 32'h3F000000, 1'b1);          // 1-0.5 = 0.5
      @(negedge i_clk);
      check("tie_ready0", 32'(b1.o_req0_ready), 32'd1);
      check("tie_ready1", 32'(b1.o_req1_ready), 32'd0);
      @(posedge i_clk); #1;
      drop1(0);
      wait_rsp1(lat);
      check("post_rst_lat", 32'(lat), 32'd1);
      check("post_rst_data0", b1.o_rsp_data, 32'h40400000);
      check("post_rst_id0", 32'(b1.o_rsp_id), 32'd0);
      @(negedge i_clk);
      check("post_rst_ready1", 32'(b1.o_req1_ready), 32'd1);
      @(posedge i_clk); #1;
      drop1(1);
      wait_rsp1(lat);
      check("post_rst_data1", b1.o_rsp_data, 32'h3F000000);
      check("post_rst_id1", 32'(b1.o_rsp_id), 32'd1);
      @(negedge i_clk);
      drain1("end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
